fifo_stack_sched: RTL and testbench

//  Byte-level scheduler/arbiter for one bit-serial FIFO_STACK instance in the USB3300 receive path.
//  Two byte producers (A: ULPI parser, B: aux/status) share the FIFO.
//  One byte consumer drains it.

---
 rtl/fifo_stack_sched.sv | 173 +++++++++++++++++
 tb/tb_fifo_stack_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stack_sched.sv
// Byte scheduler for a bit-serial FIFO: arbitrates two byte producers and one consumer,
// serialising bytes LSB first. Optional FLUSH state when FIFO_STACK_SCHED_FLUSH_EN is defined.
`timescale 1ns/1ps
module fifo_stack_sched #(
  parameter int N_STACK_SIZE = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
`ifdef FIFO_STACK_SCHED_FLUSH_EN
  input  logic                                 flush,
`endif
  input  logic [7:0]                           a_data,
  input  logic                                 a_valid,
  output logic                                 a_ready,
  input  logic [7:0]                           b_data,
  input  logic                                 b_valid,
  output logic                                 b_ready,
  input  logic                                 rd_req,
  output logic [7:0]                           rd_data,
  output logic                                 rd_valid,
  output logic [$clog2(N_STACK_SIZE/8+1)-1:0]  bytes_avail,
  output logic                                 err,
  output logic                                 fifo_data_in,
  output logic                                 fifo_in_ctrl,
  output logic                                 fifo_out_ctrl,
  input  logic                                 fifo_data_out,
  input  logic                                 fifo_overflow
);

  localparam int CW = $clog2(N_STACK_SIZE + 1);
  localparam int BW = $clog2(N_STACK_SIZE / 8 + 1);
  localparam logic [CW-1:0] RD_MIN   = CW'(8);
  localparam logic [CW-1:0] WR_LIMIT = CW'(N_STACK_SIZE - 8);
  localparam logic [CW-1:0] FULL     = CW'(N_STACK_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
`ifdef FIFO_STACK_SCHED_FLUSH_EN
    READ,
    FLUSH
`else
    READ
`endif
  } stateT;

  stateT         state_q, state_d;
  logic [CW-1:0] bitCount_q, bitCount_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    rdShreg_q, rdShreg_d;
  logic [7:0]    rdData_q, rdData_d;
  logic          rdValid_q, rdValid_d;
  logic          lastOpRead_q, lastOpRead_d;
  logic          rrFavourB_q, rrFavourB_d;
  logic          err_q, err_d;

  logic rdOk, wrOk, pickB, aGrant, bGrant, inCtrl, outCtrl, dataIn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bitCount_q   <= '0;
      bitIdx_q     <= '0;
      shreg_q      <= '0;
      rdShreg_q    <= '0;
      rdData_q     <= '0;
      rdValid_q    <= 1'b0;
      lastOpRead_q <= 1'b0;
      rrFavourB_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitCount_q   <= bitCount_d;
      bitIdx_q     <= bitIdx_d;
      shreg_q      <= shreg_d;
      rdShreg_q    <= rdShreg_d;
      rdData_q     <= rdData_d;
      rdValid_q    <= rdValid_d;
      lastOpRead_q <= lastOpRead_d;
      rrFavourB_q  <= rrFavourB_d;
      err_q        <= err_d;
    end
  end

  // The rd_valid cycle makes no grant, so ready never coincides with it and a
  // still-held rd_req cannot start a second read.
  always_comb begin
    state_d      = state_q;
    bitCount_d   = bitCount_q;
    bitIdx_d     = bitIdx_q;
    shreg_d      = shreg_q;
    rdShreg_d    = rdShreg_q;
    rdData_d     = rdData_q;
    rdValid_d    = 1'b0;
    lastOpRead_d = lastOpRead_q;
    rrFavourB_d  = rrFavourB_q;
    err_d        = err_q;
    pickB        = 1'b0;
    aGrant       = 1'b0;
    bGrant       = 1'b0;
    inCtrl       = 1'b0;
    outCtrl      = 1'b0;
    dataIn       = 1'b0;
    rdOk         = rd_req && (bitCount_q >= RD_MIN);
    wrOk         = (a_valid || b_valid) && (bitCount_q <= WR_LIMIT);

    case (state_q)
      IDLE: begin
`ifdef FIFO_STACK_SCHED_FLUSH_EN
        if (flush) begin
          if (bitCount_q != '0) state_d = FLUSH;
        end else
`endif
        if (!rdValid_q) begin
          if (rdOk && (!wrOk || !lastOpRead_q)) begin
            state_d      = READ;
            bitIdx_d     = '0;
            lastOpRead_d = 1'b1;
          end else if (wrOk) begin
            pickB        = b_valid && (!a_valid || rrFavourB_q);
            aGrant       = !pickB;
            bGrant       = pickB;
            shreg_d      = pickB ? b_data : a_data;
            rrFavourB_d  = !rrFavourB_q;
            lastOpRead_d = 1'b0;
            state_d      = WRITE;
            bitIdx_d     = '0;
          end
        end
      end
      WRITE: begin
        inCtrl   = 1'b1;
        dataIn   = shreg_q[bitIdx_q];
        if (bitCount_q != FULL) bitCount_d = bitCount_q + CW'(1);
        if (fifo_overflow) err_d = 1'b1;
        bitIdx_d = bitIdx_q + 3'd1;
        if (bitIdx_q == 3'd7) state_d = IDLE;
      end
      READ: begin
        outCtrl = 1'b1;
        if (bitCount_q != '0) bitCount_d = bitCount_q - CW'(1);
        rdShreg_d[bitIdx_q] = fifo_data_out;
        bitIdx_d = bitIdx_q + 3'd1;
        if (bitIdx_q == 3'd7) begin
          rdData_d  = rdShreg_d;
          rdValid_d = 1'b1;
          state_d   = IDLE;
        end
      end
`ifdef FIFO_STACK_SCHED_FLUSH_EN
      FLUSH: begin
        outCtrl = 1'b1;
        if (bitCount_q != '0) bitCount_d = bitCount_q - CW'(1);
        if (bitCount_q <= CW'(1)) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Grants are combinational on the producer valids, so they are masked while reset is held.
  assign a_ready       = aGrant && !rst;
  assign b_ready       = bGrant && !rst;
  assign fifo_in_ctrl  = inCtrl;
  assign fifo_out_ctrl = outCtrl;
  assign fifo_data_in  = dataIn;
  assign rd_data       = rdData_q;
  assign rd_valid      = rdValid_q;
  assign err           = err_q;
  assign bytes_avail   = BW'(bitCount_q >> 3);

endmodule

// File: tb/tb_fifo_stack_sched.sv
// Directed bench for fifo_stack_sched with a bit-serial FIFO model and a byte scoreboard.
// Define FIFO_STACK_SCHED_FLUSH_EN to also exercise the flush path.
`timescale 1ns/1ps
module tb_fifo_stack_sched;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
`ifdef FIFO_STACK_SCHED_FLUSH_EN
  logic       flush = 1'b0;
`endif
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic       rd_req = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] bytes_avail;
  logic       err;
  logic       fifo_data_in, fifo_in_ctrl, fifo_out_ctrl;
  logic       fifo_data_out, fifo_overflow;
  logic       forceOvf = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_stack_sched #(.N_STACK_SIZE(N)) dut (
    .clk(clk),
    .rst(rst),
`ifdef FIFO_STACK_SCHED_FLUSH_EN
    .flush(flush),
`endif
    .a_data(a_data),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .b_data(b_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .rd_req(rd_req),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .bytes_avail(bytes_avail),
    .err(err),
    .fifo_data_in(fifo_data_in),
    .fifo_in_ctrl(fifo_in_ctrl),
    .fifo_out_ctrl(fifo_out_ctrl),
    .fifo_data_out(fifo_data_out),
    .fifo_overflow(fifo_overflow)
  );

  // Bit-serial FIFO model sharing the scheduler reset.
  bit         mem [N];
  logic [7:0] wp, rp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (fifo_in_ctrl) begin
        mem[wp[5:0]] <= fifo_data_in;
        wp <= wp + 8'd1;
      end
      if (fifo_out_ctrl) rp <= rp + 8'd1;
    end
  end
  assign fifo_data_out = mem[rp[5:0]];
  assign fifo_overflow = forceOvf | (fifo_in_ctrl && ((wp - rp) == 8'(N)));

  // Mid-cycle monitor: accepted bytes feed the scoreboard, completed reads are queued for comparison.
  logic [7:0] expQ[$];
  logic [7:0] obsQ[$];
  int         grantOrder[$];
  int         opQ[$];
  int         aGrantCnt = 0, bGrantCnt = 0, rdValidCnt = 0;
  int         inCtrlCnt = 0, outCtrlCnt = 0, ctrlOverlap = 0, readyOverlap = 0;
  logic       prevIn = 1'b0, prevOut = 1'b0;
  logic [7:0] pushedByte = '0;

  always @(negedge clk) begin
    if (a_ready) begin
      aGrantCnt <= aGrantCnt + 1;
      expQ.push_back(a_data);
      grantOrder.push_back(0);
    end
    if (b_ready) begin
      bGrantCnt <= bGrantCnt + 1;
      expQ.push_back(b_data);
      grantOrder.push_back(1);
    end
    if (rd_valid) begin
      rdValidCnt <= rdValidCnt + 1;
      obsQ.push_back(rd_data);
    end
    if (fifo_in_ctrl) begin
      inCtrlCnt  <= inCtrlCnt + 1;
      pushedByte <= {fifo_data_in, pushedByte[7:1]};
    end
    if (fifo_out_ctrl) outCtrlCnt <= outCtrlCnt + 1;
    if (fifo_in_ctrl && !prevIn) opQ.push_back(1);
    if (fifo_out_ctrl && !prevOut) opQ.push_back(0);
    if (fifo_in_ctrl && fifo_out_ctrl) ctrlOverlap <= ctrlOverlap + 1;
    if (rd_valid && (a_ready || b_ready)) readyOverlap <= readyOverlap + 1;
    prevIn  <= fifo_in_ctrl;
    prevOut <= fifo_out_ctrl;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic aV, input logic [7:0] aD,
                               input logic bV, input logic [7:0] bD, input logic rdR);
    a_valid = aV;
    a_data  = aD;
    b_valid = bV;
    b_data  = bD;
    rd_req  = rdR;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    expQ.delete();
    obsQ.delete();
    rst = 1'b0;
    tick();
  endtask

  task automatic writeA(input logic [7:0] d);
    int start;
    int t;
    start = aGrantCnt;
    t = 0;
    a_data  = d;
    a_valid = 1'b1;
    while (aGrantCnt == start && t < 40) begin
      tick();
      t++;
    end
    a_valid = 1'b0;
    checkOutput("grant to A", aGrantCnt - start, 1);
    tick(8);
  endtask

  task automatic compareReads();
    logic [7:0] obs;
    while (obsQ.size() > 0) begin
      obs = obsQ.pop_front();
      if (expQ.size() > 0) checkOutput("rd_data vs scoreboard", obs, expQ.pop_front());
      else checkOutput("scoreboard depth at rd_valid", expQ.size(), 1);
    end
  endtask

  task automatic readN(input int n);
    int start;
    int t;
    start = rdValidCnt;
    t = 0;
    rd_req = 1'b1;
    while (rdValidCnt < start + n && t < 12 * n + 20) begin
      tick();
      t++;
    end
    rd_req = 1'b0;
    checkOutput("rd_valid count", rdValidCnt - start, n);
    compareReads();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, lastA, lastB, t, opBase, oBase, o0, i0, r0, g0;

    // Reset values, checked while reset is asserted.
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("reset control outputs",
                {a_ready, b_ready, rd_valid, err, fifo_in_ctrl, fifo_out_ctrl, fifo_data_in}, 0);
    checkOutput("reset rd_data", rd_data, 8'h00);
    checkOutput("reset bytes_avail", bytes_avail, 0);
    tick(2);
    rst = 1'b0;
    tick();

    // Empty FIFO: a read request must stall.
    o0 = outCtrlCnt;
    rd_req = 1'b1;
    tick(6);
    rd_req = 1'b0;
    checkOutput("empty stall out_ctrl cycles", outCtrlCnt - o0, 0);

    // Single byte round trip.
    i0 = inCtrlCnt;
    writeA(8'hA5);
    checkOutput("push cycles for one byte", inCtrlCnt - i0, 8);
    checkOutput("serial bits LSB first", pushedByte, 8'hA5);
    checkOutput("bytes_avail after write", bytes_avail, 1);
    r0 = rdValidCnt;
    readN(1);
    tick(3);
    checkOutput("rd_valid pulses", rdValidCnt - r0, 1);
    checkOutput("rd_data held", rd_data, 8'hA5);
    checkOutput("bytes_avail after read", bytes_avail, 0);

    // Both producers held: alternate grants until full.
    doReset();
    base  = grantOrder.size();
    g0    = aGrantCnt + bGrantCnt;
    lastA = aGrantCnt;
    lastB = bGrantCnt;
    applyStimulus(1'b1, 8'h10, 1'b1, 8'h20, 1'b0);
    for (int k = 0; k < 100; k++) begin
      tick();
      if (aGrantCnt != lastA) begin
        lastA = aGrantCnt;
        a_data = a_data + 8'd1;
      end
      if (bGrantCnt != lastB) begin
        lastB = bGrantCnt;
        b_data = b_data + 8'd1;
      end
    end
    checkOutput("bytes accepted until full", (aGrantCnt + bGrantCnt) - g0, 8);
    checkOutput("bytes_avail when full", bytes_avail, 8);
    checkOutput("ready held low when full", {a_ready, b_ready}, 2'b00);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("grant order %0d", k),
                  (grantOrder.size() > base + k) ? grantOrder[base + k] : 9, k % 2);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    readN(8);

    // Reads and writes competing: they alternate, starting with a read.
    doReset();
    writeA(8'hC1);
    writeA(8'hC2);
    opBase = opQ.size();
    lastA  = aGrantCnt;
    t      = 0;
    applyStimulus(1'b1, 8'h50, 1'b0, 8'h00, 1'b1);
    while (opQ.size() - opBase < 4 && t < 80) begin
      tick();
      t++;
      if (aGrantCnt != lastA) begin
        lastA = aGrantCnt;
        a_data = a_data + 8'd1;
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick(12);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("op order %0d", k),
                  (opQ.size() > opBase + k) ? opQ[opBase + k] : 9, k % 2);
    readN(int'(bytes_avail));
    checkOutput("in_ctrl/out_ctrl overlap", ctrlOverlap, 0);
    checkOutput("ready/rd_valid overlap", readyOverlap, 0);

    // Asynchronous reset in WRITE cycle 3, then the next grant goes to A.
    writeA(8'h11);
    g0 = aGrantCnt + bGrantCnt;
    t  = 0;
    applyStimulus(1'b1, 8'h22, 1'b1, 8'h33, 1'b0);
    while ((aGrantCnt + bGrantCnt) == g0 && t < 40) begin
      tick();
      t++;
    end
    tick(3);
    checkOutput("in_ctrl before reset", fifo_in_ctrl, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("async reset outputs",
                {a_ready, b_ready, rd_valid, err, fifo_in_ctrl, fifo_out_ctrl, fifo_data_in}, 0);
    checkOutput("async reset rd_data", rd_data, 8'h00);
    checkOutput("async reset bytes_avail", bytes_avail, 0);
    tick();
    expQ.delete();
    obsQ.delete();
    oBase = grantOrder.size();
    rst = 1'b0;
    t = 0;
    while (grantOrder.size() == oBase && t < 40) begin
      tick();
      t++;
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("first grant after reset is A",
                (grantOrder.size() > oBase) ? grantOrder[oBase] : 9, 0);
    tick(8);
    checkOutput("bytes_avail after reset write", bytes_avail, 1);
    readN(1);

    // Overflow handling: only WRITE cycles set err, which stays set until reset.
    doReset();
    forceOvf = 1'b1;
    tick(3);
    forceOvf = 1'b0;
    checkOutput("err ignores idle overflow", err, 1'b0);
    g0 = aGrantCnt;
    t  = 0;
    a_data  = 8'h77;
    a_valid = 1'b1;
    while (aGrantCnt == g0 && t < 40) begin
      tick();
      t++;
    end
    a_valid = 1'b0;
    tick(2);
    forceOvf = 1'b1;
    tick();
    forceOvf = 1'b0;
    checkOutput("err set by overflow in WRITE", err, 1'b1);
    tick(8);
    writeA(8'h78);
    checkOutput("err sticky", err, 1'b1);
    doReset();
    checkOutput("err cleared by reset", err, 1'b0);

`ifdef FIFO_STACK_SCHED_FLUSH_EN
    // Flush drains every stored bit without producing read data.
    writeA(8'h01);
    writeA(8'h02);
    writeA(8'h03);
    checkOutput("bytes_avail before flush", bytes_avail, 3);
    o0 = outCtrlCnt;
    r0 = rdValidCnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(30);
    checkOutput("flush pop cycles", outCtrlCnt - o0, 24);
    checkOutput("bytes_avail after flush", bytes_avail, 0);
    checkOutput("no rd_valid during flush", rdValidCnt - r0, 0);
    checkOutput("FIFO model empty after flush", wp - rp, 0);
    expQ.delete();
`endif

    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
